// File: rtl/carry_save_adder_4bit.sv
// Three-operand unsigned adder: a 3:2 carry-save stage followed by a ripple
// carry-propagate stage, with the full (WIDTH+2)-bit result registered.
module carry_save_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH:0]   Sum,
  output logic             ovf
);

  localparam int TW = WIDTH + 2;

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic fa_maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  logic [WIDTH-1:0] s_s;
  logic [WIDTH:0]   c_s;
  logic [TW-1:0]    op_s_s;
  logic [TW-1:0]    op_c_s;
  logic [TW:0]      rc_s;
  logic [TW-1:0]    t_s;
  logic [WIDTH:0]   sum_r;
  logic             ovf_r;

  // carry-save stage: bitwise 3:2 compression of A, B, C
  always_comb begin
    s_s    = {WIDTH{1'b0}};
    c_s    = {(WIDTH+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      s_s[i]   = fa_sum(A[i], B[i], C[i]);
      c_s[i+1] = fa_maj(A[i], B[i], C[i]);
    end
  end

  // carry-propagate stage: ripple chain of full adders over the zero-extended vectors
  always_comb begin
    op_s_s  = {2'b00, s_s};
    op_c_s  = {1'b0, c_s};
    rc_s    = {(TW+1){1'b0}};
    t_s     = {TW{1'b0}};
    for (int i = 0; i < TW; i++) begin
      t_s[i]    = fa_sum(op_s_s[i], op_c_s[i], rc_s[i]);
      rc_s[i+1] = fa_maj(op_s_s[i], op_c_s[i], rc_s[i]);
    end
  end

  // result register; the top bit of the exact sum lands in ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= {(WIDTH+1){1'b0}};
      ovf_r <= 1'b0;
    end else begin
      sum_r <= t_s[WIDTH:0];
      ovf_r <= t_s[WIDTH+1];
    end
  end

  assign Sum = sum_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_carry_save_adder_4bit.sv
// Self-checking bench for carry_save_adder_4bit: directed vectors, a shuffled
// exhaustive sweep of all input triples, and reset pulses, against an arithmetic model.
module tb_carry_save_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A, B, C;
  logic [4:0] Sum;
  logic       ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int   exp_sum;
  logic model_valid;

  carry_save_adder_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .Sum   (Sum),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // reference: exact arithmetic sum of the operands seen at each rising edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_sum <= 0;
    else        exp_sum <= int'(A) + int'(B) + int'(C);
  end

  // compare process: mid-cycle, the registered {ovf,Sum} must equal the model
  always @(negedge clk) begin
    if (model_valid) check("cycle_sum", int'({ovf, Sum}), exp_sum);
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    #1;
    A = a; B = b; C = c;
  endtask

  task automatic directed(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input int sum_req, input int ovf_req);
    drive(a, b, c);
    @(posedge clk);
    #1;
    check({name, "_sum"}, int'(Sum), sum_req);
    check({name, "_ovf"}, int'(ovf), ovf_req);
    check({name, "_model"}, exp_sum, ovf_req * 32 + sum_req);
  endtask

  int idx[4096];

  initial begin
    model_valid = 1'b0;
    rst_n = 1'b0;
    A = 4'hF; B = 4'hF; C = 4'hF;
    #2;
    check("reset_sum_no_edge", int'(Sum), 0);
    check("reset_ovf_no_edge", int'(ovf), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_valid = 1'b1;

    directed("all_ones",  4'b1111, 4'b1111, 4'b1111, 13, 1);
    directed("mixed",     4'b0101, 4'b1010, 4'b1100, 27, 0);
    directed("disjoint",  4'b1000, 4'b0100, 4'b0010, 14, 0);
    directed("zeros",     4'b0000, 4'b0000, 4'b0000, 0,  0);
    directed("max_no_ovf", 4'b1111, 4'b1111, 4'b0001, 31, 0);
    directed("ovf_edge",  4'b1111, 4'b1111, 4'b0010, 0,  1);

    // back-to-back changes every cycle, checked by the compare process
    for (int i = 0; i < 20; i++)
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));

    // asynchronous reset pulse between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_sum", int'(Sum), 0);
    check("midreset_ovf", int'(ovf), 0);
    #1;
    rst_n = 1'b1;

    // exhaustive sweep of all triples in shuffled order
    for (int i = 0; i < 4096; i++) idx[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i));
      tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(idx[i]);
      drive(v[11:8], v[7:4], v[3:0]);
    end

    @(negedge clk);
    @(negedge clk);
    model_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
